// File: rtl/aes_result_buffer.sv
// Output stage behind the pipelined AES engine: captures ciphertext blocks
// into a first-word-fall-through FIFO and hands them to the host over
// valid/ready. Tracks blocks in flight so that issue credit is only granted
// when a FIFO slot is reserved, and discards in-flight blocks after a flush.
module aes_result_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 128,
  parameter int LAT    = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     flush,
  output logic                     credit_ok,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              blk_cnt,
  output logic                     err_ovf,
  output logic                     err_unexp
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  // Headroom so over-issue past credit cannot wrap the counters.
  localparam int CW = $clog2(DEPTH + LAT + 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0]       level_q, level_next;
  logic [CW-1:0]       inflight_q, inflight_d;
  logic [CW-1:0]       drop_q, drop_d;
  logic [DATA_W-1:0]   out_data_q;
  logic [31:0]         cnt_q;
  logic                err_ovf_q, err_unexp_q;
  logic                push, push_ok, pop, full, ovf, unexp;

  assign full       = (level_q == LW'(DEPTH));
  assign pop        = out_valid && out_ready;
  assign push_ok    = push && (!full || pop);
  assign ovf        = push && full && !pop;
  assign rd_next    = rd_ptr + PW'(pop);
  assign level_next = level_q + LW'(push_ok) - LW'(pop);

  assign out_valid  = (level_q != '0);
  assign out_data   = out_data_q;
  assign level      = level_q;
  assign blk_cnt    = cnt_q;
  assign err_ovf    = err_ovf_q;
  assign err_unexp  = err_unexp_q;
  assign credit_ok  = (state_q == RUN) && ((int'(level_q) + int'(inflight_q)) < DEPTH);

  // Next-state: in-flight / drop bookkeeping, push qualification, RUN/DRAIN.
  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    push       = 1'b0;
    unexp      = 1'b0;
    case (state_q)
      RUN: begin
        unexp = in_valid && (inflight_q == '0);
        if (flush) begin
          // A block arriving in the flush cycle is discarded here, not counted.
          drop_d     = inflight_q - CW'(in_valid && (inflight_q != '0));
          inflight_d = '0;
        end else begin
          push       = in_valid;
          inflight_d = inflight_q + CW'(issue) - CW'(in_valid && (inflight_q != '0));
        end
      end
      DRAIN: begin
        if (flush) begin
          drop_d     = drop_q + inflight_q - CW'(in_valid);
          inflight_d = '0;
        end else begin
          inflight_d = inflight_q + CW'(issue);
          drop_d     = drop_q - CW'(in_valid);
        end
      end
      default: ;
    endcase
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  // Control registers: FSM state and in-flight / drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO pointers and occupancy; flush empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= rd_next;
      level_q <= level_next;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= in_data;
  end

  // Registered head word; the new block is forwarded when it becomes head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
    end else if (flush || level_next == '0) begin
      out_data_q <= '0;
    end else if (push_ok && (wr_ptr == rd_next)) begin
      out_data_q <= in_data;
    end else begin
      out_data_q <= mem[rd_next];
    end
  end

  // Delivered-block counter and sticky error flags (reset only).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      if (pop)   cnt_q       <= cnt_q + 32'd1;
      if (ovf)   err_ovf_q   <= 1'b1;
      if (unexp) err_unexp_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_result_buffer.sv
// Self-checking bench for aes_result_buffer: directed scenarios plus a
// randomized phase, compared every cycle against a queue-based model.
module tb_aes_result_buffer;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 128;
  localparam int LAT    = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              flush = 1'b0;
  logic              credit_ok;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4:0]        level;
  logic [31:0]       blk_cnt;
  logic              err_ovf;
  logic              err_unexp;

  aes_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .in_data(in_data),
    .in_valid(in_valid), .flush(flush), .credit_ok(credit_ok),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .blk_cnt(blk_cnt), .err_ovf(err_ovf), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int unsigned edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] mq[$];
  int                m_infl = 0;
  int                m_drop = 0;
  logic [31:0]       m_cnt = '0;
  logic              m_ovf = 1'b0;
  logic              m_unexp = 1'b0;
  bit                m_pop, m_run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_infl = 0; m_drop = 0; m_cnt = '0; m_ovf = 1'b0; m_unexp = 1'b0;
    end else begin
      m_pop = (mq.size() != 0) && out_ready;
      m_run = (m_drop == 0);
      if (m_run && in_valid && m_infl == 0) m_unexp = 1'b1;
      if (m_pop) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (flush) begin
        mq.delete();
        if (m_run) m_drop = m_infl - ((in_valid && m_infl > 0) ? 1 : 0);
        else       m_drop = m_drop + m_infl - (in_valid ? 1 : 0);
        m_infl = 0;
      end else if (!m_run) begin
        m_infl = m_infl + (issue ? 1 : 0);
        if (in_valid) m_drop = m_drop - 1;
      end else begin
        m_infl = m_infl + (issue ? 1 : 0) - ((in_valid && m_infl > 0) ? 1 : 0);
        if (in_valid) begin
          if (mq.size() < DEPTH) mq.push_back(in_data);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 128'(level), 128'(mq.size()));
      chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      chk("credit_ok", 128'(credit_ok),
          128'((m_drop == 0) && (mq.size() + m_infl < DEPTH)));
      chk("blk_cnt", 128'(blk_cnt), 128'(m_cnt));
      chk("err_ovf", 128'(err_ovf), 128'(m_ovf));
      chk("err_unexp", 128'(err_unexp), 128'(m_unexp));
    end
  end

  // ---------------- engine model + driver ----------------
  typedef struct {
    int unsigned       due;
    logic [DATA_W-1:0] d;
  } blk_t;
  blk_t pipe[$];

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of inputs (called at posedge+3), then advance to next posedge+3.
  task automatic step(input logic iss, input logic [DATA_W-1:0] iss_d, input logic fl,
                      input logic rdy, input logic inj, input logic [DATA_W-1:0] inj_d);
    blk_t b;
    issue = iss; flush = fl; out_ready = rdy;
    in_valid = 1'b0; in_data = rnd128();
    if (iss) begin
      b.due = edge_cnt + 1 + LAT;
      b.d = iss_d;
      pipe.push_back(b);
    end
    if (pipe.size() != 0 && pipe[0].due == edge_cnt + 1) begin
      in_valid = 1'b1; in_data = pipe[0].d;
      void'(pipe.pop_front());
    end else if (inj) begin
      in_valid = 1'b1; in_data = inj_d;
    end
    @(posedge clk); #3;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, 1'b0, rdy, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int unsigned iss_edge;
  logic [DATA_W-1:0] tag;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 128'(level), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_credit_ok", 128'(credit_ok), 128'd1);
    chk("rst_blk_cnt", 128'(blk_cnt), 128'd0);
    chk("rst_errs", 128'({err_ovf, err_unexp}), 128'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: single block, latency and data
    iss_edge = edge_cnt + 1;
    step(1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) idle(1'b1);
    chk("t1_latency", 128'(edge_cnt - iss_edge), 128'd11);
    chk("t1_data", out_data, 128'h3925841d02dc09fbdc118597196a0b32);
    idle(1'b1);
    chk("t1_blk_cnt", 128'(blk_cnt), 128'd1);
    chk("t1_level", 128'(level), 128'd0);

    // 4: flush with 2 blocks queued and 5 in flight
    step(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, '0);
    repeat (12) idle(1'b0);
    chk("t4_pre_level", 128'(level), 128'd2);
    repeat (5) step(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, '0);
    repeat (3) idle(1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("t4_flush_level", 128'(level), 128'd0);
    chk("t4_flush_valid", 128'(out_valid), 128'd0);
    chk("t4_drain_credit", 128'(credit_ok), 128'd0);
    repeat (15) idle(1'b0);
    chk("t4_after_level", 128'(level), 128'd0);
    chk("t4_after_credit", 128'(credit_ok), 128'd1);
    chk("t4_unexp", 128'(err_unexp), 128'd0);
    chk("t4_blk_cnt", 128'(blk_cnt), 128'd1);

    // 5: unexpected block, still delivered
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff);
    chk("t5_valid", 128'(out_valid), 128'd1);
    chk("t5_data", out_data, 128'h00112233445566778899aabbccddeeff);
    chk("t5_unexp", 128'(err_unexp), 128'd1);
    idle(1'b1);
    chk("t5_blk_cnt", 128'(blk_cnt), 128'd2);

    // 2: fill to DEPTH, credit exhaustion, overflow
    for (int i = 0; i < 16; i++) begin
      tag = 128'hA5A5_0000_0000_0000_0000_0000_0000_0000 | 128'(i);
      step(1'b1, tag, 1'b0, 1'b0, 1'b0, '0);
      if (i == 14) chk("t2_credit15", 128'(credit_ok), 128'd1);
      if (i == 15) chk("t2_credit16", 128'(credit_ok), 128'd0);
    end
    repeat (12) idle(1'b0);
    chk("t2_level_full", 128'(level), 128'd16);
    chk("t2_credit_full", 128'(credit_ok), 128'd0);
    chk("t2_ovf_clear", 128'(err_ovf), 128'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 128'hDEAD);
    chk("t2_ovf", 128'(err_ovf), 128'd1);
    chk("t2_level_kept", 128'(level), 128'd16);

    // 3: push+pop at full, then drain in order across the pointer wrap
    chk("t3_head0", 128'(out_data[31:0]), 128'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 128'hA5A5_0000_0000_0000_0000_0000_0000_0010);
    chk("t3_level_16", 128'(level), 128'd16);
    for (int k = 1; k <= 16; k++) begin
      chk("t3_order", 128'(out_data[31:0]), 128'(k));
      idle(1'b1);
    end
    chk("t3_level_0", 128'(level), 128'd0);
    chk("t3_blk_cnt", 128'(blk_cnt), 128'd19);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      logic fl, rdy, iss;
      fl  = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 3) != 0) && !((c / 100) % 4 == 3);
      iss = !fl && (credit_ok ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0));
      step(iss, rnd128(), fl, rdy, 1'b0, '0);
    end
    repeat (40) idle(1'b1);

    // 6: counter wrap and asynchronous reset mid-burst
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, rnd128());
    force dut.cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    chk("t6_preload", 128'(blk_cnt), 128'hFFFF_FFFF);
    idle(1'b1);
    chk("t6_wrap", 128'(blk_cnt), 128'd0);
    repeat (4) step(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, '0);
    repeat (12) idle(1'b0);
    idle(1'b1);
    chk("t6_pre_rst_level", 128'(level), 128'd3);
    rst_n = 1'b0;
    issue = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pipe.delete();
    #1;
    chk("t6_rst_level", 128'(level), 128'd0);
    chk("t6_rst_valid", 128'(out_valid), 128'd0);
    chk("t6_rst_data", out_data, 128'd0);
    chk("t6_rst_credit", 128'(credit_ok), 128'd1);
    chk("t6_rst_blk_cnt", 128'(blk_cnt), 128'd0);
    chk("t6_rst_errs", 128'({err_ovf, err_unexp}), 128'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) idle(1'b1);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
